// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Summary  : Shared state encodings and sizing helpers for fifo_rd_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [STATE_W-1:0] ST_BURST = 1'b1;

    // Wide enough to count up to a BURST_MAX of 16.
    localparam int BCNT_W = 5;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Summary  : Combinational rotate-priority picker starting after last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CW = clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CW-1:0]   i_last_idx,
    output logic [N_CH-1:0] o_gnt,
    output logic [CW-1:0]   o_gnt_idx,
    output logic            o_any
);

    always_comb begin
        int cand;
        cand      = 0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        // Channel (last+1) has highest priority; the last winner is checked last.
        for (int k = 1; k <= N_CH; k++) begin
            cand = (int'(i_last_idx) + k) % N_CH;
            if (!o_any && i_req[cand]) begin
                o_gnt[cand] = 1'b1;
                o_gnt_idx   = CW'(cand);
                o_any       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Summary  : Round-robin burst scheduler draining FWFT FIFOs into one stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4,
    localparam int CW = clog2(N_CH)
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic [N_CH-1:0]   fifo_empty,
    input  logic [N_CH*DW-1:0] fifo_data,
    output logic [N_CH-1:0]   fifo_rd_en,
    output logic              m_valid,
    output logic [DW-1:0]     m_data,
    output logic [CW-1:0]     m_ch,
    output logic              m_last,
    input  logic              m_ready,
    output logic [N_CH-1:0]   grant,
    output logic              busy
);

    localparam logic [BCNT_W-1:0] c_burst_max  = BCNT_W'(BURST_MAX);
    localparam logic [BCNT_W-1:0] c_burst_last = BCNT_W'(BURST_MAX - 1);
    localparam logic [CW-1:0]     c_last_rst   = CW'(N_CH - 1);

    logic [STATE_W-1:0] r_state_q,      w_state_d;
    logic [N_CH-1:0]    r_grant_q,      w_grant_d;
    logic [CW-1:0]      r_last_grant_q, w_last_grant_d;
    logic [BCNT_W-1:0]  r_beat_cnt_q,   w_beat_cnt_d;
    logic               r_m_valid_q,    w_m_valid_d;
    logic [DW-1:0]      r_m_data_q,     w_m_data_d;
    logic [CW-1:0]      r_m_ch_q,       w_m_ch_d;
    logic               r_m_last_q,     w_m_last_d;

    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_arb_gnt;
    logic [CW-1:0]   w_arb_idx;
    logic            w_arb_any;
    logic            w_slot_free;
    logic            w_g_empty;
    logic [DW-1:0]   w_g_data;
    logic            w_load;

    assign w_req = ~fifo_empty;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .i_req      (w_req),
        .i_last_idx (r_last_grant_q),
        .o_gnt      (w_arb_gnt),
        .o_gnt_idx  (w_arb_idx),
        .o_any      (w_arb_any)
    );

    // One-hot grant select of the granted channel's flag and head word.
    always_comb begin
        w_g_data  = '0;
        w_g_empty = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (r_grant_q[i]) begin
                w_g_data  = fifo_data[i*DW +: DW];
                w_g_empty = fifo_empty[i];
            end
        end
    end

    assign w_slot_free = !r_m_valid_q || m_ready;
    assign w_load      = (r_state_q == ST_BURST) && w_slot_free && !w_g_empty
                         && (r_beat_cnt_q < c_burst_max);

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_grant_q      <= '0;
            r_last_grant_q <= c_last_rst;
            r_beat_cnt_q   <= '0;
            r_m_valid_q    <= 1'b0;
            r_m_data_q     <= '0;
            r_m_ch_q       <= '0;
            r_m_last_q     <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_grant_q      <= w_grant_d;
            r_last_grant_q <= w_last_grant_d;
            r_beat_cnt_q   <= w_beat_cnt_d;
            r_m_valid_q    <= w_m_valid_d;
            r_m_data_q     <= w_m_data_d;
            r_m_ch_q       <= w_m_ch_d;
            r_m_last_q     <= w_m_last_d;
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_grant_d      = r_grant_q;
        w_last_grant_d = r_last_grant_q;
        w_beat_cnt_d   = r_beat_cnt_q;
        w_m_valid_d    = r_m_valid_q;
        w_m_data_d     = r_m_data_q;
        w_m_ch_d       = r_m_ch_q;
        w_m_last_d     = r_m_last_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_state_d      = ST_BURST;
                    w_grant_d      = w_arb_gnt;
                    w_last_grant_d = w_arb_idx;
                    w_beat_cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (w_load) begin
                    w_beat_cnt_d = r_beat_cnt_q + BCNT_W'(1);
                    if (r_beat_cnt_q == c_burst_last) begin
                        w_state_d = ST_IDLE;
                        w_grant_d = '0;
                    end
                end else if (w_slot_free && w_g_empty) begin
                    // Channel ran dry before a full burst: end without m_last.
                    w_state_d = ST_IDLE;
                    w_grant_d = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
            end
        endcase

        if (w_load) begin
            w_m_valid_d = 1'b1;
            w_m_data_d  = w_g_data;
            w_m_ch_d    = r_last_grant_q;
            w_m_last_d  = (r_beat_cnt_q == c_burst_last);
        end else if (w_slot_free) begin
            w_m_valid_d = 1'b0;
        end
    end

    always_comb begin
        fifo_rd_en = w_load ? r_grant_q : '0;
        busy       = (r_state_q == ST_BURST);
        grant      = r_grant_q;
        m_valid    = r_m_valid_q;
        m_data     = r_m_data_q;
        m_ch       = r_m_ch_q;
        m_last     = r_m_last_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Summary  : Self-checking bench: FIFO-queue model plus round-robin burst model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int N_CH = 4;
    localparam int DW = 8;
    localparam int BURST_MAX = 4;
    localparam int CW = 2;
    localparam int DEPTH = 64;
    localparam int MAXB = 256;

    logic rclk = 1'b0;
    logic rst;
    logic [N_CH-1:0] fifo_empty;
    logic [N_CH*DW-1:0] fifo_data;
    logic [N_CH-1:0] fifo_rd_en;
    logic m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_ch;
    logic m_last;
    logic m_ready;
    logic [N_CH-1:0] grant;
    logic busy;

    fifo_rd_arbiter #(.N_CH(N_CH), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .rclk(rclk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ch(m_ch),
        .m_last(m_last), .m_ready(m_ready), .grant(grant), .busy(busy)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [N_CH][DEPTH];
    int rp [N_CH];
    int wp [N_CH];
    int obs_n, exp_n, gr_n, egr_n;
    int obs_ch [MAXB];
    int exp_ch [MAXB];
    int obs_cyc [MAXB];
    logic [DW-1:0] obs_data [MAXB];
    logic [DW-1:0] exp_data [MAXB];
    logic obs_last [MAXB];
    logic exp_last [MAXB];
    logic [N_CH-1:0] gr_log [64];
    int egr [64];
    int pop_cnt [N_CH];
    int pop_tot, viol_pop, viol_grant, viol_hold, stall_cnt, busy_cyc;
    int cyc, rpat, ready_mode, mdl_last;
    int n_checks, n_fail;
    logic stalled_prev;
    logic [DW-1:0] hold_data;
    logic [CW-1:0] hold_ch;
    logic hold_last;
    logic [N_CH-1:0] prev_grant;
    bit to;

    task automatic refresh();
        for (int i = 0; i < N_CH; i++) begin
            fifo_empty[i] = (rp[i] == wp[i]);
            fifo_data[i*DW +: DW] = mem[i][rp[i] % DEPTH];
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] val);
        mem[ch][wp[ch] % DEPTH] = val;
        wp[ch]++;
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N_CH; i++) if (rp[i] != wp[i]) e = 1'b0;
        return e;
    endfunction

    task automatic clear_obs();
        obs_n = 0; gr_n = 0; pop_tot = 0; viol_pop = 0; viol_grant = 0;
        viol_hold = 0; stall_cnt = 0; busy_cyc = 0;
        for (int i = 0; i < N_CH; i++) pop_cnt[i] = 0;
    endtask

    // Called at a falling edge: observe, let the rising edge pass, then apply pops.
    task automatic cycle();
        logic [N_CH-1:0] rd;
        if (m_valid && m_ready && obs_n < MAXB) begin
            obs_ch[obs_n] = int'(m_ch); obs_data[obs_n] = m_data;
            obs_last[obs_n] = m_last; obs_cyc[obs_n] = cyc; obs_n++;
        end
        if (fifo_rd_en != '0) begin
            if ($countones(fifo_rd_en) != 1 || (fifo_rd_en & fifo_empty) != '0
                || (m_valid && !m_ready) || !busy) viol_pop++;
            pop_tot++;
            for (int i = 0; i < N_CH; i++) if (fifo_rd_en[i]) pop_cnt[i]++;
        end
        if ((grant != '0 && $countones(grant) != 1) || (busy != (grant != '0))) viol_grant++;
        if (stalled_prev && (!m_valid || m_data !== hold_data || m_ch !== hold_ch
            || m_last !== hold_last)) viol_hold++;
        stalled_prev = m_valid && !m_ready && !rst;
        if (stalled_prev) stall_cnt++;
        hold_data = m_data; hold_ch = m_ch; hold_last = m_last;
        if (busy) busy_cyc++;
        if (grant != '0 && prev_grant == '0 && gr_n < 64) begin
            gr_log[gr_n] = grant; gr_n++;
        end
        prev_grant = grant;
        rd = fifo_rd_en;
        @(posedge rclk);
        #1;
        for (int i = 0; i < N_CH; i++) if (rd[i]) rp[i]++;
        refresh();
        case (ready_mode)
            1: m_ready = ($urandom % 4) != 0;
            2: begin m_ready = (rpat % 3) == 0; rpat++; end
            default: m_ready = 1'b1;
        endcase
        cyc++;
        @(negedge rclk);
    endtask

    task automatic drain(output bit timed_out);
        int t;
        t = 0;
        while (!(all_empty() && !busy && !m_valid) && t < 2000) begin
            cycle();
            t++;
        end
        timed_out = (t >= 2000);
    endtask

    // Reference: static FIFO contents drained round-robin, min(BURST_MAX, count) per grant.
    task automatic build_expected();
        int cnt [N_CH];
        int pos [N_CH];
        int c, n;
        bit done;
        exp_n = 0; egr_n = 0; done = 1'b0;
        for (int i = 0; i < N_CH; i++) begin cnt[i] = wp[i] - rp[i]; pos[i] = rp[i]; end
        for (int r = 0; r < 1000 && !done; r++) begin
            c = -1;
            for (int k = 1; k <= N_CH; k++)
                if (c < 0 && cnt[(mdl_last + k) % N_CH] > 0) c = (mdl_last + k) % N_CH;
            if (c < 0) begin
                done = 1'b1;
            end else begin
                n = (cnt[c] < BURST_MAX) ? cnt[c] : BURST_MAX;
                egr[egr_n] = c; egr_n++;
                for (int j = 0; j < n; j++) begin
                    exp_ch[exp_n] = c;
                    exp_data[exp_n] = mem[c][pos[c] % DEPTH];
                    exp_last[exp_n] = (n == BURST_MAX) && (j == n - 1);
                    pos[c]++; exp_n++;
                end
                cnt[c] -= n;
                mdl_last = c;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; mdl_last = N_CH - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cycle(); cycle();
        push(2, 8'h5A); refresh();
        cycle();
        n_checks += 7;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_data !== '0) begin n_fail++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        if (m_ch !== '0) begin n_fail++; $display("FAIL rst_m_ch: got %0d want 0", m_ch); end
        if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        if (grant !== '0) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (fifo_rd_en !== '0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0000", fifo_rd_en); end
        rst = 1'b0; mdl_last = N_CH - 1;
        clear_obs(); build_expected(); drain(to);
        n_checks += 2;
        if (to) begin n_fail++; $display("FAIL rst_drain_timeout: got timeout want drained"); end
        if (obs_n !== 1 || obs_ch[0] !== 2 || obs_data[0] !== 8'h5A) begin
            n_fail++; $display("FAIL rst_first_beat: got n=%0d ch%0d %h want n=1 ch2 5a", obs_n, obs_ch[0], obs_data[0]);
        end
    endtask

    task automatic test_single_channel();
        clear_obs();
        push(1, 8'hA1); push(1, 8'hB2); push(1, 8'hC3); refresh();
        build_expected();
        cycle();
        n_checks++;
        if (busy !== 1'b1 || grant !== 4'b0010 || fifo_rd_en !== 4'b0010) begin
            n_fail++; $display("FAIL single_first_pop: got busy=%b grant=%b rd_en=%b want 1 0010 0010", busy, grant, fifo_rd_en);
        end
        drain(to);
        n_checks += 4;
        if (to) begin n_fail++; $display("FAIL single_timeout: got timeout want drained"); end
        if (obs_n !== 3) begin n_fail++; $display("FAIL single_count: got %0d want 3", obs_n); end
        if (pop_cnt[1] !== 3 || pop_tot !== 3) begin n_fail++; $display("FAIL single_pops: got %0d want 3", pop_tot); end
        if (viol_pop !== 0 || viol_grant !== 0) begin n_fail++; $display("FAIL single_protocol: got %0d/%0d want 0/0", viol_pop, viol_grant); end
        for (int i = 0; i < 3 && i < obs_n; i++) begin
            n_checks++;
            if (obs_ch[i] !== 1 || obs_data[i] !== exp_data[i] || obs_last[i] !== 1'b0) begin
                n_fail++; $display("FAIL single_beat%0d: got ch%0d %h last%b want ch1 %h last0", i, obs_ch[i], obs_data[i], obs_last[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_fairness();
        pulse_reset(); clear_obs();
        for (int c = 0; c < N_CH; c++) for (int j = 0; j < 8; j++) push(c, 8'($urandom));
        refresh(); build_expected(); drain(to);
        n_checks += 4;
        if (to) begin n_fail++; $display("FAIL fair_timeout: got timeout want drained"); end
        if (obs_n !== exp_n) begin n_fail++; $display("FAIL fair_count: got %0d want %0d", obs_n, exp_n); end
        if (gr_n !== 8) begin n_fail++; $display("FAIL fair_grants: got %0d want 8", gr_n); end
        if (viol_pop !== 0 || viol_grant !== 0) begin n_fail++; $display("FAIL fair_protocol: got %0d/%0d want 0/0", viol_pop, viol_grant); end
        for (int i = 0; i < gr_n && i < 8; i++) begin
            n_checks++;
            if (gr_log[i] !== 4'(1 << (i % N_CH))) begin
                n_fail++; $display("FAIL fair_order%0d: got %b want ch%0d", i, gr_log[i], i % N_CH);
            end
        end
        for (int i = 0; i < obs_n && i < exp_n; i++) begin
            n_checks++;
            if (obs_ch[i] !== exp_ch[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL fair_beat%0d: got ch%0d %h last%b want ch%0d %h last%b", i, obs_ch[i], obs_data[i], obs_last[i], exp_ch[i], exp_data[i], exp_last[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (obs_cyc[i] - obs_cyc[i-1] !== ((i % BURST_MAX == 0) ? 2 : 1)) begin
                    n_fail++; $display("FAIL fair_gap%0d: got %0d cycles want %0d", i, obs_cyc[i] - obs_cyc[i-1], (i % BURST_MAX == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_wrap();
        clear_obs();
        push(0, 8'h10); push(0, 8'h11); push(3, 8'h30); push(3, 8'h31); refresh();
        build_expected();
        cycle();
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant: got %b want 0001", grant); end
        drain(to);
        n_checks += 2;
        if (to || obs_n !== 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", obs_n); end
        if (gr_n !== 2 || gr_log[1] !== 4'b1000) begin n_fail++; $display("FAIL wrap_second: got %b want 1000", gr_log[1]); end
        for (int i = 0; i < obs_n && i < exp_n; i++) begin
            n_checks++;
            if (obs_ch[i] !== exp_ch[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL wrap_beat%0d: got ch%0d %h want ch%0d %h", i, obs_ch[i], obs_data[i], exp_ch[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_obs();
        ready_mode = 2; rpat = 1; m_ready = 1'b1;
        for (int j = 0; j < 4; j++) push(2, 8'($urandom));
        refresh(); build_expected(); drain(to);
        ready_mode = 0; m_ready = 1'b1;
        n_checks += 5;
        if (to || obs_n !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", obs_n); end
        if (viol_hold !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls want 0", viol_hold); end
        if (viol_pop !== 0) begin n_fail++; $display("FAIL bp_pop: got %0d bad pops want 0", viol_pop); end
        if (pop_cnt[2] !== 4) begin n_fail++; $display("FAIL bp_pops: got %0d want 4", pop_cnt[2]); end
        if (stall_cnt == 0) begin n_fail++; $display("FAIL bp_stalls: got 0 stalls want >0"); end
        for (int i = 0; i < obs_n && i < exp_n; i++) begin
            n_checks++;
            if (obs_ch[i] !== exp_ch[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL bp_beat%0d: got ch%0d %h last%b want ch%0d %h last%b", i, obs_ch[i], obs_data[i], obs_last[i], exp_ch[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            clear_obs();
            for (int c = 0; c < N_CH; c++) begin
                n = $urandom_range(0, 10);
                for (int j = 0; j < n; j++) push(c, 8'($urandom));
            end
            refresh(); build_expected(); drain(to);
            n_checks += 3;
            if (to || obs_n !== exp_n) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_n, exp_n); end
            if (viol_pop !== 0 || viol_grant !== 0 || viol_hold !== 0) begin
                n_fail++; $display("FAIL rand%0d_protocol: got %0d/%0d/%0d want 0/0/0", r, viol_pop, viol_grant, viol_hold);
            end
            if (gr_n !== egr_n) begin n_fail++; $display("FAIL rand%0d_grants: got %0d want %0d", r, gr_n, egr_n); end
            for (int i = 0; i < obs_n && i < exp_n; i++) begin
                n_checks++;
                if (obs_ch[i] !== exp_ch[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d: got ch%0d %h last%b want ch%0d %h last%b", r, i, obs_ch[i], obs_data[i], obs_last[i], exp_ch[i], exp_data[i], exp_last[i]);
                end
            end
        end
        ready_mode = 0; m_ready = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        pulse_reset(); clear_obs();
        for (int j = 0; j < 6; j++) push(0, 8'(8'h40 + j));
        refresh();
        cycle(); cycle(); cycle();
        rst = 1'b1;
        push(1, 8'h71); push(1, 8'h72); refresh();
        cycle();
        n_checks++;
        if (m_valid !== 1'b0 || grant !== '0 || fifo_rd_en !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got valid=%b grant=%b rd_en=%b busy=%b want 0 0000 0000 0", m_valid, grant, fifo_rd_en, busy);
        end
        rst = 1'b0; mdl_last = N_CH - 1;
        clear_obs(); build_expected();
        cycle();
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_regrant: got %b want 0001", grant); end
        drain(to);
        n_checks++;
        if (to || obs_n !== exp_n) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", obs_n, exp_n); end
        for (int i = 0; i < obs_n && i < exp_n; i++) begin
            n_checks++;
            if (obs_ch[i] !== exp_ch[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL midrst_beat%0d: got ch%0d %h last%b want ch%0d %h last%b", i, obs_ch[i], obs_data[i], obs_last[i], exp_ch[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_empty_all();
        clear_obs();
        for (int t = 0; t < 100; t++) cycle();
        n_checks += 3;
        if (pop_tot !== 0) begin n_fail++; $display("FAIL empty_pops: got %0d want 0", pop_tot); end
        if (busy_cyc !== 0 || gr_n !== 0) begin n_fail++; $display("FAIL empty_idle: got busy=%0d grants=%0d want 0/0", busy_cyc, gr_n); end
        if (m_valid !== 1'b0 || grant !== '0) begin n_fail++; $display("FAIL empty_final: got valid=%b grant=%b want 0 0000", m_valid, grant); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; rpat = 0; ready_mode = 0;
        mdl_last = N_CH - 1; stalled_prev = 1'b0; prev_grant = '0;
        hold_data = '0; hold_ch = '0; hold_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            rp[i] = 0; wp[i] = 0;
            for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
        end
        rst = 1'b1; m_ready = 1'b1; fifo_empty = '1; fifo_data = '0;
        refresh();
        clear_obs();
        @(negedge rclk);
        test_reset();
        test_single_channel();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_random();
        test_reset_mid_burst();
        test_empty_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
